gate_exerciser: RTL

GATE_EXERCISER -- requirements
Module: gate_exerciser

---
 rtl/gate_exerciser_pkg.sv | 15 +
 rtl/rise_detect.sv | 19 +
 rtl/gate_exerciser.sv | 99 +++++++++
 3 files changed

// File: rtl/gate_exerciser_pkg.sv
// rtl/gate_exerciser_pkg.sv - shared state type and sizing constants for gate_exerciser
package gate_exerciser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector; register resets high so a level
// already asserted at reset release is not mistaken for an edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b1;
    else        q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - walks all four {b,a} vectors through a 2-input gate and
// reports pass or the first mismatching vector.
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  TRUTH         = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] fail_idx
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       LAST_IDX    = 2'(NUM_VECTORS - 1);

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             start_edge;
  logic             mismatch;

  rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (start),
    .rise (start_edge)
  );

  assign mismatch = (dut_y != TRUTH[idx]);

  // Stimulus is updated on the edge entering DRIVE so the pins already show the
  // current vector during the DRIVE cycle itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 2'd0;
      cnt      <= '0;
      err      <= 1'b0;
      dut_a    <= 1'b0;
      dut_b    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_idx <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state          <= DRIVE;
            idx            <= 2'd0;
            err            <= 1'b0;
            fail_idx       <= 2'd0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            {dut_b, dut_a} <= 2'b00;
          end
        end
        DRIVE: begin
          {dut_b, dut_a} <= idx;
          cnt            <= SETTLE_LOAD;
          state          <= SETTLE;
        end
        SETTLE: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          if (mismatch && !err) begin
            err      <= 1'b1;
            fail_idx <= idx;
          end
          if (idx == LAST_IDX) begin
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            pass           <= !(err || mismatch);
            {dut_b, dut_a} <= 2'b00;
          end else begin
            idx            <= idx + 2'd1;
            {dut_b, dut_a} <= idx + 2'd1;
            state          <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
